multibyte_add_seq: RTL and testbench

Sequencer that performs NBYTES-wide add/subtract operations one byte per cycle through the shared 8-bit carry-lookahead byte adder. It latches wide operands on a start handshake and streams byte pairs, least-significant byte first, into the byte adder's operand and carry inputs. It chains the adder's carry-out back into the next byte's carry-in and assembles the result and status flags. It sits between the register file / operand bus (upstream) and the byte adder (downstream), and consumes the adder's sum and carry outputs.

---
 rtl/multibyte_add_seq_if.sv | 36 +++
 rtl/multibyte_add_seq.sv | 147 ++++++++++++++
 tb/tb_multibyte_add_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/multibyte_add_seq_if.sv
// Operand/result bus and byte-adder link for the multibyte add/subtract sequencer.
// master = upstream/environment side, slave = sequencer side.
interface multibyte_add_seq_if #(
    parameter int unsigned NBYTES = 4
);
    localparam int unsigned W = 8 * NBYTES;

    logic           start;
    logic [1:0]     op;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           flag_c;
    logic           flag_z;
    logic           flag_n;
    logic           flag_v;
    logic [7:0]     adder_a;
    logic [7:0]     adder_b;
    logic           adder_cin;
    logic [7:0]     adder_sum;
    logic           adder_cout;

    modport master (
        output start, op, opa, opb, adder_sum, adder_cout,
        input  busy, done, result, flag_c, flag_z, flag_n, flag_v,
               adder_a, adder_b, adder_cin
    );

    modport slave (
        input  start, op, opa, opb, adder_sum, adder_cout,
        output busy, done, result, flag_c, flag_z, flag_n, flag_v,
               adder_a, adder_b, adder_cin
    );
endinterface

// File: rtl/multibyte_add_seq.sv
// Byte-serial NBYTES-wide ADD/ADC/SUB/SBC sequencer driving an external 8-bit adder,
// LSB first, chaining carry-out into the next byte's carry-in.
module multibyte_add_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multibyte_add_seq_if.slave      bus
);
    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IDXW = (NBYTES > 2) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q,  state_d;
    logic [W-1:0]    a_q,      a_d;
    logic [W-1:0]    b_q,      b_d;
    logic            sub_q,    sub_d;
    logic            cin0_q,   cin0_d;
    logic [IDXW-1:0] idx_q,    idx_d;
    logic            chain_q,  chain_d;
    logic            zacc_q,   zacc_d;
    logic [W-1:0]    result_q, result_d;
    logic            fc_q,     fc_d;
    logic            fz_q,     fz_d;
    logic            fn_q,     fn_d;
    logic            fv_q,     fv_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;

    logic            run_c;
    logic            accept_c;
    logic            last_c;
    logic [7:0]      a_byte_c;
    logic [7:0]      b_byte_c;
    logic            cin_c;

    // Current byte pair and carry-in presented to the external adder
    always_comb begin
        run_c    = (state_q == S_RUN);
        last_c   = (idx_q == LAST_IDX);
        accept_c = bus.start && (state_q != S_RUN);
        a_byte_c = a_q[{idx_q, 3'b000} +: 8];
        b_byte_c = b_q[{idx_q, 3'b000} +: 8] ^ {8{sub_q}};
        cin_c    = (idx_q == '0) ? cin0_q : chain_q;
    end

    assign bus.adder_a   = run_c ? a_byte_c : 8'h00;
    assign bus.adder_b   = run_c ? b_byte_c : 8'h00;
    assign bus.adder_cin = run_c ? cin_c    : 1'b0;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        cin0_d   = cin0_q;
        idx_d    = idx_q;
        chain_d  = chain_q;
        zacc_d   = zacc_q;
        result_d = result_q;
        fc_d     = fc_q;
        fz_d     = fz_q;
        fn_d     = fn_q;
        fv_d     = fv_q;

        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last_c)    state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // ADC/SBC take flag_c as it stands at the accept edge
        if (accept_c) begin
            a_d    = bus.opa;
            b_d    = bus.opb;
            sub_d  = bus.op[1];
            cin0_d = bus.op[0] ? fc_q : bus.op[1];
            idx_d  = '0;
            zacc_d = 1'b1;
        end

        if (run_c) begin
            result_d[{idx_q, 3'b000} +: 8] = bus.adder_sum;
            chain_d = bus.adder_cout;
            idx_d   = idx_q + IDXW'(1);
            zacc_d  = zacc_q & (bus.adder_sum == 8'h00);
            if (last_c) begin
                fc_d = bus.adder_cout;
                fn_d = bus.adder_sum[7];
                fz_d = zacc_q & (bus.adder_sum == 8'h00);
                fv_d = (a_byte_c[7] == b_byte_c[7]) && (bus.adder_sum[7] != a_byte_c[7]);
            end
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            cin0_q   <= 1'b0;
            idx_q    <= '0;
            chain_q  <= 1'b0;
            zacc_q   <= 1'b0;
            result_q <= '0;
            fc_q     <= 1'b0;
            fz_q     <= 1'b0;
            fn_q     <= 1'b0;
            fv_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            cin0_q   <= cin0_d;
            idx_q    <= idx_d;
            chain_q  <= chain_d;
            zacc_q   <= zacc_d;
            result_q <= result_d;
            fc_q     <= fc_d;
            fz_q     <= fz_d;
            fn_q     <= fn_d;
            fv_q     <= fv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.flag_c = fc_q;
    assign bus.flag_z = fz_q;
    assign bus.flag_n = fn_q;
    assign bus.flag_v = fv_q;
endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq: behavioural byte adder, word-level reference model,
// directed cases plus randomized back-to-back / spaced operations.
module tb_multibyte_add_seq;
    localparam int unsigned NBYTES = 4;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic m_c    = 1'b0;
    logic [31:0] obs_r;
    logic [3:0]  obs_f;

    multibyte_add_seq_if #(.NBYTES(NBYTES)) bus ();

    multibyte_add_seq #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit byte adder
    always_comb begin
        {bus.adder_cout, bus.adder_sum} = 9'(bus.adder_a) + 9'(bus.adder_b) + 9'(bus.adder_cin);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Whole-word reference: A + B_eff + cin, with signed overflow from integer range
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] f);
        logic [31:0] be;
        logic        cin;
        logic [32:0] full;
        longint      s;
        be   = op[1] ? ~b : b;
        cin  = op[0] ? m_c : op[1];
        full = {1'b0, a} + {1'b0, be} + 33'(cin);
        r    = full[31:0];
        s    = longint'($signed(a)) + longint'($signed(be)) + longint'(cin);
        f[3] = full[32];
        f[2] = (r == 32'h0);
        f[1] = r[31];
        f[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        m_c  = full[32];
    endtask

    // Issue one op at the current negedge; returns at the done negedge
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at);
        logic [31:0] er;
        logic [3:0]  ef;
        int          cyc;
        int          busy_cnt;
        bit          seen;
        model(op, a, b, er, ef);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        cyc = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            bus.start = (cyc == inject_at);
            bus.op    = 2'($urandom);
            bus.opa   = $urandom;
            bus.opb   = $urandom;
            if (bus.busy) busy_cnt++;
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        obs_r = bus.result;
        obs_f = {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v};
        chk("done_seen",    64'(seen), 64'(1));
        chk("latency",      64'(cyc), 64'(NBYTES + 1));
        chk("busy_cycles",  64'(busy_cnt), 64'(NBYTES));
        chk("busy_at_done", 64'(bus.busy), 64'(0));
        chk("result",       64'(obs_r), 64'(er));
        chk("flags_czNv",   64'(obs_f), 64'(ef));
    endtask

    initial begin
        int extra;
        logic [31:0] ra, rb;
        bit b2b;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.opa   = '0;
        bus.opb   = '0;
        #12;
        chk("rst_busy",   64'(bus.busy), 64'(0));
        chk("rst_done",   64'(bus.done), 64'(0));
        chk("rst_result", 64'(bus.result), 64'(0));
        chk("rst_flags",  64'({bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}), 64'(0));
        chk("rst_adder",  64'({bus.adder_a, bus.adder_b, bus.adder_cin}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'h000000FF, 32'h00000001, 0);
        chk("t1_res", 64'(obs_r), 64'h100);
        chk("t1_flg", 64'(obs_f), 64'(4'b0000));
        @(negedge clk);
        chk("done_pulse", 64'(bus.done), 64'(0));
        chk("idle_adder", 64'({bus.adder_a, bus.adder_b, bus.adder_cin}), 64'(0));

        run_op(2'b00, 32'hFFFFFFFF, 32'h00000001, 0);
        chk("t2_res", 64'(obs_r), 64'h0);
        chk("t2_flg", 64'(obs_f), 64'(4'b1100));
        run_op(2'b01, 32'h00000001, 32'h00000001, 0);
        chk("adc_res", 64'(obs_r), 64'h3);
        chk("adc_flg", 64'(obs_f), 64'(4'b0000));
        @(negedge clk);

        run_op(2'b10, 32'h80000000, 32'h00000001, 0);
        chk("sub1_res", 64'(obs_r), 64'h7FFFFFFF);
        chk("sub1_flg", 64'(obs_f), 64'(4'b1001));
        @(negedge clk);
        run_op(2'b10, 32'h00000001, 32'h00000002, 0);
        chk("sub2_res", 64'(obs_r), 64'hFFFFFFFF);
        chk("sub2_flg", 64'(obs_f), 64'(4'b0010));
        @(negedge clk);
        run_op(2'b11, 32'h00000005, 32'h00000002, 0);
        chk("sbc_res", 64'(obs_r), 64'h2);
        chk("sbc_flg", 64'(obs_f), 64'(4'b1000));
        @(negedge clk);

        // start pulsed while busy must be ignored
        run_op(2'b00, 32'h01020304, 32'h10203040, 2);
        chk("inj_res", 64'(obs_r), 64'h11223344);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        chk("inj_single_done", 64'(extra), 64'(0));

        // Asynchronous reset in the third RUN cycle
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.opa   = 32'h12345678;
        bus.opb   = 32'h11111111;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_busy",   64'(bus.busy), 64'(0));
        chk("ar_done",   64'(bus.done), 64'(0));
        chk("ar_result", 64'(bus.result), 64'(0));
        chk("ar_flags",  64'({bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}), 64'(0));
        chk("ar_adder",  64'({bus.adder_a, bus.adder_b, bus.adder_cin}), 64'(0));
        m_c = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        chk("ar_no_done", 64'(extra), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 32'h12345678, 32'h11111111, 0);
        chk("ar_retry_res", 64'(obs_r), 64'h23456789);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 32'h0;
                1:       ra = 32'hFFFFFFFF;
                2:       ra = 32'h80000000;
                default: ra = $urandom;
            endcase
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            b2b = 1'($urandom_range(0, 1));
            run_op(2'($urandom), ra, rb, 0);
            if (!b2b) begin
                @(negedge clk);
                chk("rnd_done_pulse", 64'(bus.done), 64'(0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
